// File: rtl/bsg_fifo_rolly_replay_sender.sv
// bsg_fifo_rolly_replay_sender: go-back-N sender that turns link responses and a
// response timeout into rolly FIFO incr/ack/rollback pulses.
module bsg_fifo_rolly_replay_sender #(
  parameter int width_p = 8,
  parameter int lg_size_p = 3,
  parameter int max_outstanding_p = 1 << lg_size_p,
  parameter int timeout_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] fifo_data_i,
  input  logic               fifo_v_i,
  output logic               fifo_yumi_o,
  output logic               fifo_incr_v_o,
  output logic               fifo_ack_v_o,
  output logic               fifo_rollback_v_o,
  output logic [width_p-1:0] link_data_o,
  output logic               link_epoch_o,
  output logic               link_v_o,
  input  logic               link_ready_i,
  input  logic               resp_v_i,
  input  logic [1:0]         resp_code_i,
  input  logic               resp_epoch_i
);
  localparam int ow = $clog2(max_outstanding_p + 1);
  localparam int tw = $clog2(timeout_p);
  localparam logic [ow-1:0] max_c = ow'(max_outstanding_p);
  localparam logic [tw-1:0] last_c = tw'(timeout_p - 1);
  typedef enum logic [1:0] {NONE, INCR, ACK, RB} act_e;
  act_e act_r, act_n;
  logic [ow-1:0] outstanding_r, outstanding_n;
  logic [tw-1:0] timer_r, timer_n;
  logic epoch_r, match, ack_one, ack_all, nack, busy, timeout;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      act_r <= NONE;
      outstanding_r <= '0;
      epoch_r <= 1'b0;
      timer_r <= '0;
    end else begin
      act_r <= act_n;
      outstanding_r <= outstanding_n;
      epoch_r <= epoch_r ^ (act_n == RB);
      timer_r <= timer_n;
    end
  end
  always_comb begin
    match = resp_v_i & (resp_epoch_i == epoch_r) & (resp_code_i != 2'b00);
    nack = match & (resp_code_i == 2'b11);
    ack_all = match & (resp_code_i == 2'b10);
    ack_one = match & (resp_code_i == 2'b01);
    busy = outstanding_r != '0;
    timeout = busy & (timer_r == last_c);
    act_n = (nack | timeout) ? RB : (ack_all & busy) ? ACK : (ack_one & busy) ? INCR : NONE;
  end
  // Popping is held off whenever this cycle's ack/rollback would already cover the entry.
  always_comb begin
    fifo_incr_v_o = act_r == INCR;
    fifo_ack_v_o = act_r == ACK;
    fifo_rollback_v_o = act_r == RB;
    link_v_o = fifo_v_i & (act_r != RB) & (act_n != ACK) & (act_n != RB) & (outstanding_r < max_c);
    fifo_yumi_o = link_v_o & link_ready_i;
    link_data_o = fifo_data_i;
    link_epoch_o = epoch_r;
  end
  always_comb begin
    outstanding_n = (act_n == ACK || act_n == RB) ? '0
                  : outstanding_r + ow'(fifo_yumi_o) - ow'(act_n == INCR);
    timer_n = (act_n != NONE || outstanding_n == '0 || (fifo_yumi_o && !busy)) ? '0
            : (timer_r == last_c) ? timer_r : timer_r + tw'(1);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0({fifo_incr_v_o, fifo_ack_v_o, fifo_rollback_v_o}));
      assert (!(act_n == INCR && !busy));
      assert (!((ack_one | ack_all) && !busy));
    end
  end
endmodule

// File: tb/tb_bsg_fifo_rolly_replay_sender.sv
// tb_bsg_fifo_rolly_replay_sender: directed vectors, corner sequences and a
// queue-based reference model under random traffic.
module tb_bsg_fifo_rolly_replay_sender;
  localparam int W = 8, MAX = 4, TO = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [W-1:0] fifo_data = '0, link_data;
  logic fifo_v = 1'b0, link_ready = 1'b0, resp_v = 1'b0, resp_epoch = 1'b0;
  logic [1:0] resp_code = 2'b00;
  logic yumi, incr, ack, rb, link_epoch, link_v;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  bsg_fifo_rolly_replay_sender #(
    .width_p(W), .lg_size_p(3), .max_outstanding_p(MAX), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .fifo_data_i(fifo_data), .fifo_v_i(fifo_v),
    .fifo_yumi_o(yumi), .fifo_incr_v_o(incr), .fifo_ack_v_o(ack),
    .fifo_rollback_v_o(rb), .link_data_o(link_data), .link_epoch_o(link_epoch),
    .link_v_o(link_v), .link_ready_i(link_ready), .resp_v_i(resp_v),
    .resp_code_i(resp_code), .resp_epoch_i(resp_epoch)
  );
  typedef struct {
    logic fv, rdy, rv;
    logic [1:0] code;
    logic ep;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[29];
  function automatic vec_t v(logic fv, logic rdy, logic rv, logic [1:0] c, logic e, logic [5:0] x);
    return '{fv, rdy, rv, c, e, x};
  endfunction
  function automatic logic [5:0] outs();
    return {link_v, yumi, incr, ack, rb, link_epoch};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic fv, input logic rdy, input logic rv, input logic [1:0] code,
                       input logic ep, input logic rst, input logic [W-1:0] d);
    @(negedge clk);
    reset = rst;
    fifo_v = fv;
    link_ready = rdy;
    resp_v = rv;
    resp_code = code;
    resp_epoch = ep;
    fifo_data = d;
    #1;
  endtask
  logic [W-1:0] q[$];
  logic m_ep, fv, rdy, rv, ep, matched, e_rb, e_all, e_one, e_lv, e_y;
  logic [1:0] code;
  logic [W-1:0] d;
  int pend, cyc, t0, sz, k, n;
  initial begin
    // expected outputs: {link_v, yumi, incr, ack, rb, epoch}
    tbl[0] = v(0, 0, 0, 2'd0, 0, 6'b000000);
    for (int i = 1; i <= 3; i++) tbl[i] = v(1, 1, 0, 2'd0, 0, 6'b110000);
    tbl[4] = v(0, 0, 1, 2'd1, 0, 6'b000000);
    tbl[5] = v(0, 0, 1, 2'd1, 0, 6'b001000);
    tbl[6] = v(0, 0, 1, 2'd1, 0, 6'b001000);
    tbl[7] = v(0, 0, 0, 2'd0, 0, 6'b001000);
    tbl[8] = v(0, 0, 0, 2'd0, 0, 6'b000000);
    for (int i = 9; i <= 12; i++) tbl[i] = v(1, 1, 0, 2'd0, 0, 6'b110000);
    tbl[13] = v(1, 1, 0, 2'd0, 0, 6'b000000);
    tbl[14] = v(1, 1, 1, 2'd1, 0, 6'b000000);
    tbl[15] = v(1, 1, 0, 2'd0, 0, 6'b111000);
    tbl[16] = v(0, 0, 1, 2'd1, 0, 6'b000000);
    tbl[17] = v(1, 1, 1, 2'd2, 0, 6'b001000);
    tbl[18] = v(1, 0, 0, 2'd0, 0, 6'b100100);
    tbl[19] = v(0, 0, 0, 2'd0, 0, 6'b000000);
    tbl[20] = v(1, 1, 0, 2'd0, 0, 6'b110000);
    tbl[21] = v(1, 1, 0, 2'd0, 0, 6'b110000);
    tbl[22] = v(1, 1, 1, 2'd3, 0, 6'b000000);
    tbl[23] = v(1, 1, 1, 2'd1, 0, 6'b000011);
    tbl[24] = v(1, 1, 0, 2'd0, 0, 6'b110001);
    tbl[25] = v(0, 0, 0, 2'd0, 0, 6'b000001);
    tbl[26] = v(0, 0, 1, 2'd1, 1, 6'b000001);
    tbl[27] = v(0, 0, 0, 2'd0, 0, 6'b001001);
    tbl[28] = v(0, 0, 1, 2'd0, 1, 6'b000001);
    drive(0, 0, 0, 2'd0, 0, 1, '0);
    drive(0, 0, 0, 2'd0, 0, 1, '0);
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].fv, tbl[i].rdy, tbl[i].rv, tbl[i].code, tbl[i].ep, 0, 8'(i));
      check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
    end
    // timeout with no response: pulse on the (TO+1)th cycle after the send
    drive(1, 1, 0, 2'd0, 0, 0, 8'h11);
    check("to_send", {31'd0, yumi}, 32'd1);
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      drive(0, 0, 0, 2'd0, 0, 0, '0);
      if (rb) k = i;
    end
    check("to_delay", k, TO + 1);
    check("to_epoch", {31'd0, link_epoch}, 32'd0);
    drive(0, 0, 0, 2'd0, 0, 0, '0);
    check("to_width", {31'd0, rb}, 32'd0);
    // nack arriving in the very cycle the timer expires
    drive(1, 1, 0, 2'd0, 0, 0, 8'h22);
    check("nt_send", {31'd0, yumi}, 32'd1);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(0, 0, i == 8, (i == 8) ? 2'd3 : 2'd0, 0, 0, '0);
      if (i == 9) check("nt_pulse", {31'd0, rb}, 32'd1);
      n += int'(rb);
    end
    check("nt_count", n, 1);
    check("nt_epoch", {31'd0, link_epoch}, 32'd1);
    // reset with two entries outstanding and an ack pending
    drive(1, 1, 0, 2'd0, 0, 0, 8'h33);
    drive(1, 1, 0, 2'd0, 0, 0, 8'h34);
    drive(0, 0, 1, 2'd1, 1, 1, '0);
    drive(0, 0, 0, 2'd0, 0, 0, '0);
    check("rst_outs", {26'd0, outs()}, 32'd0);
    n = 0;
    for (int i = 0; i < MAX + 1; i++) begin
      drive(1, 1, 0, 2'd0, 0, 0, 8'(i));
      n += int'(yumi);
    end
    check("rst_window", n, MAX);
    // random traffic against the reference model
    drive(0, 0, 0, 2'd0, 0, 1, '0);
    q.delete();
    m_ep = 1'b0;
    pend = 0;
    cyc = 0;
    t0 = 0;
    for (int i = 0; i < 3000; i++) begin
      fv = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      rv = $urandom_range(0, 9) == 0;
      code = 2'($urandom_range(0, 3));
      ep = ($urandom_range(0, 4) == 0) ? ~m_ep : m_ep;
      d = 8'($urandom);
      if (rv && ep == m_ep && (code == 2'd1 || code == 2'd2) && q.size() == 0) code = 2'd0;
      drive(fv, rdy, rv, code, ep, 0, d);
      matched = rv && ep == m_ep && code != 2'd0;
      sz = q.size();
      e_rb = (matched && code == 2'd3) || (sz > 0 && cyc - t0 >= TO - 1);
      e_all = !e_rb && matched && code == 2'd2 && sz > 0;
      e_one = !e_rb && !e_all && matched && code == 2'd1 && sz > 0;
      e_lv = fv && pend != 3 && !e_rb && !e_all && sz < MAX;
      e_y = e_lv && rdy;
      check("rand", {18'd0, outs(), link_data},
            {18'd0, e_lv, e_y, pend == 1, pend == 2, pend == 3, m_ep, d});
      if (e_rb || e_all) q.delete();
      else begin
        if (e_y) q.push_back(d);
        if (e_one) void'(q.pop_front());
      end
      if (e_rb) m_ep = ~m_ep;
      if (e_rb || e_all || e_one || q.size() == 0 || (e_y && sz == 0)) t0 = cyc + 1;
      pend = e_rb ? 3 : e_all ? 2 : e_one ? 1 : 0;
      cyc++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
